dpram_sync: RTL and testbench
=============================

DPRAM_SYNC -- requirements
Module: dpram_sync

Interface
REQ-001 Parameter DW, 8, data width in bits (1..64).
REQ-002 Parameter AW, 8, address width; depth is DEPTH = 2**AW words.
REQ-003 Parameter RD_LAT, 2, read latency in cycles; legal values 1 or 2.
REQ-004 Parameter RDW_MODE, 0, cross-port read-during-write result: 0 = old data, 1 = new data.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as below.
REQ-006 clk  input  1  sole clock; all state changes on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 ena / enb  input  1 each  port A / B access enable.
REQ-009 wea / web  input  1 each  1 = write, 0 = read; qualified by ena / enb.
REQ-010 addra / addrb  input  AW each  word address.
REQ-011 dina / dinb  input  DW each  write data.
REQ-012 douta / doutb  output  DW each  read data, registered.
REQ-013 vala / valb  output  1 each  one-cycle strobe: douta / doutb carries new read data.
REQ-014 clr_req  input  1  request to zero the whole array.
REQ-015 clr_busy  output  1  clear engine active; port accesses ignored.
REQ-016 coll  output  1  one-cycle strobe: both ports wrote the same address.

Function
REQ-017 Storage SHALL be DEPTH words of DW bits; every AW-bit address is legal, with no out-of-range case.
REQ-018 A port access SHALL be accepted at a rising edge only when en=1 and clr_busy=0; otherwise it SHALL have no effect.
REQ-019 An accepted write SHALL update the addressed word at that edge.
REQ-020 An accepted read at edge N SHALL place data on dout, with val=1 for exactly one cycle, after edge N+RD_LAT-1 (RD_LAT=1: next cycle; RD_LAT=2: one cycle later).
REQ-021 Back-to-back reads SHALL be fully pipelined, one result per cycle per port.
REQ-022 dout SHALL hold its last read value while val=0, never X.
REQ-023 Cross-port read/write to the same address in the same cycle SHALL return the pre-write word when RDW_MODE=0, and the writing port's din when RDW_MODE=1.
REQ-024 Simultaneous writes by both ports to the same address SHALL store dina (port A wins) and SHALL pulse coll the following cycle.
REQ-025 Writes by both ports to different addresses in the same cycle SHALL both take effect.
REQ-026 The clear FSM SHALL have states IDLE and CLEAR.
REQ-027 IDLE -> CLEAR SHALL occur when clr_req=1 is sampled; clr_busy SHALL be 1 from the next cycle while the state is CLEAR.
REQ-028 In CLEAR, an internal AW-bit counter SHALL write 0 to address 0,1,...,DEPTH-1, one word per cycle.
REQ-029 CLEAR -> IDLE SHALL occur after the DEPTH-1 write, so clr_busy is high for exactly DEPTH cycles.
REQ-030 clr_req while in CLEAR SHALL be ignored and SHALL NOT restart the counter.
REQ-031 Reads accepted before clr_busy rose SHALL complete normally with pre-clear data.
REQ-032 A port access presented in the same cycle as the clr_req edge SHALL be accepted.

Reset
REQ-033 rst_n=0 SHALL immediately force: state IDLE, counter 0, clr_busy 0, douta/doutb 0, vala/valb 0, coll 0, read pipelines flushed.
REQ-034 Memory contents SHALL NOT be altered by reset.
REQ-035 Reset asserted mid-CLEAR SHALL abort the clear, leaving words already cleared at 0 and the rest unchanged.
REQ-036 Reset asserted with reads in flight SHALL discard them, with no val strobe after release.

Verification (DW=8, AW=4, RD_LAT=2 unless stated)
REQ-037 Write A addr 3 = 0x5A, then read B addr 3 -> doutb=0x5A, valb pulse 2 cycles after read edge; doutb holds 0x5A afterwards.
REQ-038 Reads on A of addr 0..15 on consecutive cycles after fill with addr^0xF0 -> 16 consecutive vala cycles with correct data, no bubbles.
REQ-039 Addr 7 = 0x11; A writes 0x22 to addr 7 while B reads addr 7 -> doutb=0x11 (RDW_MODE=0), 0x22 (RDW_MODE=1).
REQ-040 A writes 0xAA and B writes 0xBB to addr 9 in the same cycle -> coll=1 for one cycle; later read returns 0xAA.
REQ-041 Fill all 16 words nonzero, pulse clr_req, with port writes during busy -> clr_busy high exactly 16 cycles, writes ignored, all reads return 0x00.
REQ-042 Pulse clr_req; assert rst_n=0 after 5 busy cycles -> clr_busy=0 at once, addrs 0..4 read 0, addrs 5..15 keep prior data.

Source files
------------

// File: rtl/dpram_sync.sv
// dpram_sync: true dual-port RAM with registered read pipelines, collision flag and clear engine
module dpram_sync #(
    parameter int DW       = 8,
    parameter int AW       = 8,
    parameter int RD_LAT   = 2,
    parameter int RDW_MODE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          enb,
    input  logic          wea,
    input  logic          web,
    input  logic [AW-1:0] addra,
    input  logic [AW-1:0] addrb,
    input  logic [DW-1:0] dina,
    input  logic [DW-1:0] dinb,
    input  logic          clr_req,
    output logic [DW-1:0] douta,
    output logic [DW-1:0] doutb,
    output logic          vala,
    output logic          valb,
    output logic          clr_busy,
    output logic          coll
);
    localparam int DEPTH = 2**AW;
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_a, rdata_b, d1a, d1b, d2a, d2b;
    logic v1a, v1b, v2a, v2b;
    logic wr_a, wr_b, rd_a, rd_b, same;

    assign clr_busy = (state == CLEAR);
    assign wr_a     = ena & ~clr_busy & wea;
    assign wr_b     = enb & ~clr_busy & web;
    assign rd_a     = ena & ~clr_busy & ~wea;
    assign rd_b     = enb & ~clr_busy & ~web;
    assign same     = (addra == addrb);
    assign rdata_a  = (RDW_MODE == 1 && wr_b && same) ? dinb : mem[addra];
    assign rdata_b  = (RDW_MODE == 1 && wr_a && same) ? dina : mem[addrb];
    assign douta    = (RD_LAT == 1) ? d1a : d2a;
    assign doutb    = (RD_LAT == 1) ? d1b : d2b;
    assign vala     = (RD_LAT == 1) ? v1a : v2a;
    assign valb     = (RD_LAT == 1) ? v1b : v2b;

    // clear engine next state: sweep every address once, then return to idle
    always_comb begin
        state_nxt = (state == IDLE) ? (clr_req ? CLEAR : IDLE) : (&cnt ? IDLE : CLEAR);
        cnt_nxt   = clr_busy ? cnt + 1'b1 : '0;
    end

    // clear engine state and address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // storage: clear engine owns the array while busy, port A wins a same-address collision
    always_ff @(posedge clk) begin
        if (clr_busy) begin
            mem[cnt] <= '0;
        end else begin
            if (wr_a) mem[addra] <= dina;
            if (wr_b && !(wr_a && same)) mem[addrb] <= dinb;
        end
    end

    // read pipelines and collision strobe; data registers only load on valid so outputs hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {v1a, v1b, v2a, v2b, coll} <= '0;
            {d1a, d1b, d2a, d2b}       <= '0;
        end else begin
            v1a  <= rd_a;
            v1b  <= rd_b;
            v2a  <= v1a;
            v2b  <= v1b;
            coll <= wr_a & wr_b & same;
            if (rd_a) d1a <= rdata_a;
            if (rd_b) d1b <= rdata_b;
            if (v1a) d2a <= d1a;
            if (v1b) d2b <= d1b;
        end
    end
endmodule

// File: tb/tb_dpram_sync.sv
// tb_dpram_sync: scoreboard bench for dpram_sync (DW=8, AW=4, RD_LAT=2, both RDW modes)
module tb_dpram_sync;
    logic clk = 0, rst_n = 1, ena = 0, enb = 0, wea = 0, web = 0, clr_req = 0;
    logic [3:0] addra = 0, addrb = 0;
    logic [7:0] dina = 0, dinb = 0;
    logic [7:0] douta, doutb, da1, db1, ea, eb, ec;
    logic vala, valb, clr_busy, coll, va1, vb1, cb1, co1;
    int total = 0, bad = 0, run_a = 0, max_run_a = 0;
    logic [7:0] model [16];
    logic [7:0] qa[$], qb[$], qb1[$];

    always #5 clk = ~clk;

    dpram_sync #(.DW(8), .AW(4), .RD_LAT(2), .RDW_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .enb(enb), .wea(wea), .web(web),
        .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb), .clr_req(clr_req),
        .douta(douta), .doutb(doutb), .vala(vala), .valb(valb), .clr_busy(clr_busy), .coll(coll));

    dpram_sync #(.DW(8), .AW(4), .RD_LAT(2), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .enb(enb), .wea(wea), .web(web),
        .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb), .clr_req(clr_req),
        .douta(da1), .doutb(db1), .vala(va1), .valb(vb1), .clr_busy(cb1), .coll(co1));

    // scoreboard: every read strobe pops the value queued when the read was issued
    always @(negedge clk) begin
        if (rst_n) begin
            run_a = vala ? run_a + 1 : 0;
            if (run_a > max_run_a) max_run_a = run_a;
            if (vala) begin
                total++;
                if (qa.size() == 0) begin
                    bad++;
                    $display("FAIL vala_unexpected: douta=%h with nothing outstanding", douta);
                end else begin
                    ea = qa.pop_front();
                    if (douta !== ea) begin
                        bad++;
                        $display("FAIL douta: got %h expected %h", douta, ea);
                    end
                end
            end
            if (valb) begin
                total++;
                if (qb.size() == 0) begin
                    bad++;
                    $display("FAIL valb_unexpected: doutb=%h with nothing outstanding", doutb);
                end else begin
                    eb = qb.pop_front();
                    if (doutb !== eb) begin
                        bad++;
                        $display("FAIL doutb: got %h expected %h", doutb, eb);
                    end
                end
            end
            if (vb1) begin
                total++;
                if (qb1.size() == 0) begin
                    bad++;
                    $display("FAIL valb_new_unexpected: doutb=%h with nothing outstanding", db1);
                end else begin
                    ec = qb1.pop_front();
                    if (db1 !== ec) begin
                        bad++;
                        $display("FAIL doutb_new: got %h expected %h", db1, ec);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        ena = 0; enb = 0; wea = 0; web = 0;
    endtask

    task automatic rd_a(input int a);
        ena = 1; wea = 0; addra = 4'(a);
        qa.push_back(model[a]);
    endtask

    task automatic rd_b(input int a);
        enb = 1; web = 0; addrb = 4'(a);
        qb.push_back(model[a]);
        qb1.push_back(model[a]);
    endtask

    task automatic wr_a(input int a, input logic [7:0] d);
        ena = 1; wea = 1; addra = 4'(a); dina = d;
        model[a] = d;
    endtask

    task automatic wr_b(input int a, input logic [7:0] d);
        enb = 1; web = 1; addrb = 4'(a); dinb = d;
        model[a] = d;
    endtask

    task automatic drain;
        for (int i = 0; i < 20 && (qa.size() + qb.size() + qb1.size()) != 0; i++) cyc;
        total++;
        if ((qa.size() + qb.size() + qb1.size()) != 0) begin
            bad++;
            $display("FAIL drain: outstanding reads=%0d required 0", qa.size() + qb.size() + qb1.size());
            qa.delete(); qb.delete(); qb1.delete();
        end
    endtask

    task automatic fill;
        for (int i = 0; i < 8; i++) begin
            wr_a(i, 8'(i) ^ 8'hF0);
            wr_b(i + 8, 8'(i + 8) ^ 8'hF0);
            cyc;
            total++;
            if (coll !== 1'b0) begin
                bad++;
                $display("FAIL coll_diff_addr: got %b required 0", coll);
            end
        end
        idle;
    endtask

    task automatic test_reset;
        #1 rst_n = 0;
        #1;
        total++;
        if ({douta, doutb} !== 16'h0) begin
            bad++;
            $display("FAIL reset_dout: got %h/%h required 00/00", douta, doutb);
        end
        total++;
        if ({vala, valb, coll, clr_busy} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b required 0000", {vala, valb, coll, clr_busy});
        end
        cyc;
        rst_n = 1;
        cyc;
    endtask

    task automatic test_write_read;
        wr_a(3, 8'h5A); cyc; idle;
        rd_b(3); cyc; idle;
        total++;
        if (valb !== 1'b0) begin
            bad++;
            $display("FAIL rd_lat_early: valb=%b required 0", valb);
        end
        cyc;
        total++;
        if (valb !== 1'b1 || doutb !== 8'h5A) begin
            bad++;
            $display("FAIL rd_lat: valb=%b doutb=%h required 1/5a", valb, doutb);
        end
        cyc;
        total++;
        if (valb !== 1'b0 || doutb !== 8'h5A) begin
            bad++;
            $display("FAIL rd_hold: valb=%b doutb=%h required 0/5a", valb, doutb);
        end
        drain;
    endtask

    task automatic test_burst;
        fill;
        max_run_a = 0;
        for (int i = 0; i < 16; i++) begin
            rd_a(i);
            rd_b(15 - i);
            cyc;
        end
        idle;
        drain;
        total++;
        if (max_run_a != 16) begin
            bad++;
            $display("FAIL burst_run: vala run=%0d required 16", max_run_a);
        end
    endtask

    task automatic test_rdw;
        wr_a(7, 8'h11); cyc; idle;
        ena = 1; wea = 1; addra = 4'd7; dina = 8'h22;
        enb = 1; web = 0; addrb = 4'd7;
        qb.push_back(8'h11);
        qb1.push_back(8'h22);
        model[7] = 8'h22;
        cyc; idle;
        enb = 1; web = 1; addrb = 4'd7; dinb = 8'h33;
        rd_a(7);
        model[7] = 8'h33;
        cyc; idle;
        drain;
        rd_b(7); cyc; idle;
        drain;
    endtask

    task automatic test_collision;
        wr_a(9, 8'hAA);
        wr_b(9, 8'hBB);
        model[9] = 8'hAA;
        cyc; idle;
        total++;
        if (coll !== 1'b1) begin
            bad++;
            $display("FAIL coll_pulse: got %b required 1", coll);
        end
        cyc;
        total++;
        if (coll !== 1'b0) begin
            bad++;
            $display("FAIL coll_width: got %b required 0", coll);
        end
        rd_b(9); cyc; idle;
        drain;
    endtask

    task automatic test_clear;
        int n;
        fill;
        rd_a(2);
        clr_req = 1;
        cyc;
        clr_req = 0; idle;
        total++;
        if (clr_busy !== 1'b1) begin
            bad++;
            $display("FAIL clr_start: clr_busy=%b required 1", clr_busy);
        end
        n = 1;
        for (int i = 0; i < 40 && clr_busy; i++) begin
            ena = 1; wea = 1; addra = 4'($urandom_range(0, 15)); dina = 8'h77;
            enb = 1; web = 1; addrb = 4'($urandom_range(0, 15)); dinb = 8'h66;
            clr_req = (i == 5);
            cyc;
            if (clr_busy) n++;
        end
        clr_req = 0; idle;
        total++;
        if (n != 16) begin
            bad++;
            $display("FAIL clr_len: busy cycles=%0d required 16", n);
        end
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        drain;
        for (int i = 0; i < 16; i++) begin
            rd_a(i);
            cyc;
        end
        idle;
        drain;
    endtask

    task automatic test_reset_mid_clear;
        fill;
        rd_a(1); cyc; idle;
        rst_n = 0;
        qa.delete();
        cyc;
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            cyc;
            total++;
            if (vala !== 1'b0) begin
                bad++;
                $display("FAIL flush: vala=%b required 0", vala);
            end
        end
        clr_req = 1; cyc; clr_req = 0;
        for (int i = 0; i < 5; i++) cyc;
        rst_n = 0;
        #1;
        total++;
        if (clr_busy !== 1'b0 || douta !== 8'h00) begin
            bad++;
            $display("FAIL clr_abort: clr_busy=%b douta=%h required 0/00", clr_busy, douta);
        end
        cyc;
        rst_n = 1;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        for (int i = 0; i < 16; i++) begin
            rd_a(i);
            cyc;
        end
        idle;
        drain;
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_burst;
        test_rdw;
        test_collision;
        test_clear;
        test_reset_mid_clear;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
